clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run-time programmable integer clock divider with a controller that sequences start/stop and ratio changes.
- Any ratio N in 2..2^CNT_W-1 gives 50% duty.
- Odd N uses a half-cycle extension from a negedge flop.
- New ratios are accepted through a req/ack handshake and applied only at a period boundary, so o_clk_out never has a runt pulse.
- Sits between the configuration register block and downstream logic that consumes a derived clock.

Parameters:
CNT_W, 8, width of ratio and period counter.
DIV_DEFAULT, 5, ratio loaded at reset; must be in 2..2^CNT_W-1.

Ports:
i_clk_in  input  1  source clock; all state updates on posedge except the negedge extension flop.
i_rstn  input  1  reset, asynchronous, active-low.
i_en  input  1  run enable.
i_div_req  input  1  ratio change request, single-cycle or level.
i_div_val  input  CNT_W  requested ratio, valid while i_div_req=1.
o_div_ack  output  1  one-cycle pulse when the requested ratio is applied.
o_busy  output  1  a ratio change is pending.
o_err  output  1  one-cycle pulse: requested ratio was 0 or 1, so it is rejected.
o_period_tick  output  1  high for the single cycle where cnt==N-1 in RUN.
o_clk_out  output  1  divided clock.

Behaviour:
- Reset (async, on i_rstn low; also applies to the negedge flop):
  - state=STOP, div_r=DIV_DEFAULT, cnt=0.
  - pos_q=0, neg_q=0.
  - o_clk_out=0, o_div_ack=0, o_busy=0, o_err=0, o_period_tick=0.
  - Any pending request is discarded with no ack.
- Registers:
  - div_r: active ratio N.
  - odd_r: LSB of div_r; updates together with div_r.
  - pend_r: pending ratio value.
  - cnt: 0..N-1 period counter.
- Waveform generation, per posedge in RUN:
  - cnt wraps N-1 -> 0.
  - pos_q <= (cnt_next < floor(N/2)).
  - neg_q <= pos_q on negedge.
  - o_clk_out = pos_q | (odd_r & neg_q).
  - Even N: high for N/2 cycles. Odd N: high for (N-1)/2 + 0.5 cycles. Period N cycles in both cases.
  - o_clk_out rises on the posedge where cnt becomes 0.
- States:
  - STOP: cnt=0, pos_q=0, o_clk_out low after neg_q drains (half cycle).
    - i_en=1 at posedge -> RUN. That same edge sets cnt=0 and pos_q=1, so the first rising edge has zero added latency.
  - RUN:
    - At the posedge with cnt==N-1 and i_en=0 -> STOP. The current period always completes; no truncated high phase.
    - Valid request -> SWITCH with pend_r<=i_div_val and o_busy=1 from the next cycle.
  - SWITCH:
    - Counting continues with the old N.
    - At the posedge with cnt==N-1: div_r<=pend_r, odd_r<=pend_r[0], cnt<=0, o_div_ack pulses 1 cycle, o_busy<=0.
    - Next state is RUN if i_en=1, else STOP.
    - The first period after the switch uses the new N.
- Request handling:
  - A request in STOP applies at the next posedge with an immediate ack pulse; o_busy never rises.
  - A request while o_busy=1 is ignored: no ack, no err, pend_r unchanged. The requester must wait for o_busy=0.
  - i_div_val of 0 or 1 pulses o_err for 1 cycle; state, div_r and o_busy are unchanged.
  - Request with the same value as div_r: handled as a normal switch (ack at boundary).
- Simultaneous events:
  - i_en=1 and valid request at the same posedge in STOP: the new ratio is applied and counting starts with the new N at that edge; ack pulses.
  - i_en falling while in SWITCH: the switch completes at the boundary with an ack, then STOP.
- o_period_tick: combinational from (state!=STOP && cnt==div_r-1).
- Glitch-free: for odd N, neg_q rises half a cycle after pos_q rises and falls half a cycle after pos_q falls, so the OR has a single rise and a single fall per period.

Test Plan:
1. Reset release, i_en=1, DIV_DEFAULT=5 -> o_clk_out high 2.5 cycles, low 2.5 cycles, period 5; o_period_tick every 5 cycles with cnt==4.
2. In RUN at N=5, pulse i_div_req with i_div_val=4 at cnt==1 -> o_busy=1 for cycles cnt 2..4; ack pulse at the wrap; next periods are 2 high / 2 low; no shortened pulse.
3. Ratio sweep 2, 3, 7, 255 each via handshake -> high time N/2 (even) or (N-1)/2+0.5 cycles (odd); period exactly N.
4. i_div_val=0, then 1 -> o_err pulses once each, no ack, output period unchanged; second request while o_busy=1 -> ignored, the original pending value is applied.
5. Deassert i_en mid-period at N=6, cnt==2 -> period finishes (cnt reaches 5), STOP, o_clk_out stays 0; reassert -> rising edge at the sampling posedge.
6. Assert i_rstn low during SWITCH with N=9 -> all outputs 0 immediately, no ack; after release div_r=5.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the configuration side and the clock divider.
// The master drives enable and ratio requests; the slave returns handshake status and the divided clock.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             i_en;
  logic             i_div_req;
  logic [CNT_W-1:0] i_div_val;
  logic             o_div_ack;
  logic             o_busy;
  logic             o_err;
  logic             o_period_tick;
  logic             o_clk_out;

  modport master (
    output i_en, i_div_req, i_div_val,
    input  o_div_ack, o_busy, o_err, o_period_tick, o_clk_out
  );

  modport slave (
    input  i_en, i_div_req, i_div_val,
    output o_div_ack, o_busy, o_err, o_period_tick, o_clk_out
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty integer clock divider with start/stop sequencing
// and runt-free ratio changes applied only at period boundaries.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_STOP   | output parked low, cnt held at 0, requests applied at once
//   ST_RUN    | counting with div_r, free to accept a new ratio
//   ST_SWITCH | counting with old div_r, pend_r applied at the wrap
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic               i_clk_in,
  input  logic               i_rstn,
  clk_div_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] div_r;
  logic             odd_r;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] cnt;
  logic             pos_q;
  logic             neg_q;
  logic             ack_q;
  logic             busy_q;
  logic             err_q;

  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_end;
  logic             req_ok;
  logic             req_bad;

  assign div_m1  = div_r - ONE;
  assign half    = div_r >> 1;
  assign at_end  = (cnt == div_m1);
  assign cnt_inc = at_end ? '0 : cnt + ONE;
  assign req_ok  = bus.i_div_req && (bus.i_div_val > ONE);
  assign req_bad = bus.i_div_req && (bus.i_div_val <= ONE);

  always_ff @(posedge i_clk_in or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_STOP;
      div_r  <= DIV_RST;
      odd_r  <= DIV_RST[0];
      pend_r <= DIV_RST;
      cnt    <= '0;
      pos_q  <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_STOP: begin
          cnt   <= '0;
          err_q <= req_bad;
          if (req_ok) begin
            div_r <= bus.i_div_val;
            odd_r <= bus.i_div_val[0];
            ack_q <= 1'b1;
          end
          // cnt_next is 0 and any legal N has floor(N/2) >= 1, so start high
          if (bus.i_en) begin
            state <= ST_RUN;
            pos_q <= 1'b1;
          end else begin
            pos_q <= 1'b0;
          end
        end
        ST_RUN: begin
          err_q <= req_bad;
          if (at_end && !bus.i_en) begin
            // stopping at the boundary anyway, so a request here applies directly
            state <= ST_STOP;
            cnt   <= '0;
            pos_q <= 1'b0;
            if (req_ok) begin
              div_r <= bus.i_div_val;
              odd_r <= bus.i_div_val[0];
              ack_q <= 1'b1;
            end
          end else begin
            cnt   <= cnt_inc;
            pos_q <= (cnt_inc < half);
            if (req_ok) begin
              pend_r <= bus.i_div_val;
              busy_q <= 1'b1;
              state  <= ST_SWITCH;
            end
          end
        end
        ST_SWITCH: begin
          // neg_q is already low at the wrap, so odd_r can change without a glitch
          if (at_end) begin
            div_r  <= pend_r;
            odd_r  <= pend_r[0];
            cnt    <= '0;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            pos_q  <= bus.i_en;
            state  <= bus.i_en ? ST_RUN : ST_STOP;
          end else begin
            cnt   <= cnt_inc;
            pos_q <= (cnt_inc < half);
          end
        end
        default: begin
          state  <= ST_STOP;
          cnt    <= '0;
          pos_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge i_clk_in or negedge i_rstn) begin
    if (!i_rstn) neg_q <= 1'b0;
    else         neg_q <= pos_q;
  end

  assign bus.o_clk_out     = pos_q | (odd_r & neg_q);
  assign bus.o_period_tick = (state != ST_STOP) && at_end;
  assign bus.o_div_ack     = ack_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, compared
// against a period/phase model of the divided clock and the ratio handshake.
module tb_clk_div_ctrl;

  localparam int T = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rises       = 0;

  bit m_run, m_pend, m_ack, m_err;
  int m_n, m_pval, m_phase, m_rises;

  clk_div_ctrl_if #(.CNT_W(8)) dut_if ();

  clk_div_ctrl #(.CNT_W(8), .DIV_DEFAULT(5)) dut (
    .i_clk_in (clk),
    .i_rstn   (rstn),
    .bus      (dut_if)
  );

  always #(T/2) clk = ~clk;
  always @(posedge dut_if.o_clk_out) rises++;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_ack = 0; m_err = 0;
    m_n = 5; m_pval = 0; m_phase = 0;
  endfunction

  // Divided clock is high for the first N/2 source cycles of each period.
  function automatic int exp_clk(input real f);
    return (m_run && (real'(m_phase) + f < real'(m_n) / 2.0)) ? 1 : 0;
  endfunction

  task automatic model_step(input bit en, input bit req, input int val);
    bit ok, bad, at_end;
    ok = req && val >= 2;
    bad = req && val < 2;
    m_ack = 0; m_err = 0;
    if (!m_run) begin
      if (bad) m_err = 1;
      if (ok) begin m_n = val; m_ack = 1; end
      if (en) begin m_run = 1; m_phase = 0; end
    end else if (m_pend) begin
      if (m_phase == m_n - 1) begin
        m_n = m_pval; m_pend = 0; m_ack = 1; m_phase = 0; m_run = en;
      end else begin
        m_phase++;
      end
    end else begin
      at_end = (m_phase == m_n - 1);
      if (bad) m_err = 1;
      if (at_end && !en) begin
        m_run = 0; m_phase = 0;
        if (ok) begin m_n = val; m_ack = 1; end
      end else begin
        m_phase = at_end ? 0 : m_phase + 1;
        if (ok) begin m_pend = 1; m_pval = val; end
      end
    end
    if (m_run && m_phase == 0) m_rises++;
  endtask

  // Called at 3/4 of a source cycle; returns at the same point of the next one.
  task automatic step(input bit en, input bit req, input int val);
    dut_if.i_en      = en;
    dut_if.i_div_req = req;
    dut_if.i_div_val = 8'(val);
    @(posedge clk);
    model_step(en, req, val);
    #(T/4);
    chk("ack",    dut_if.o_div_ack,     m_ack);
    chk("err",    dut_if.o_err,         m_err);
    chk("busy",   dut_if.o_busy,        m_pend);
    chk("tick",   dut_if.o_period_tick, (m_run && m_phase == m_n - 1) ? 1 : 0);
    chk("clk_hi", dut_if.o_clk_out,     exp_clk(0.25));
    @(negedge clk);
    #(T/4);
    chk("clk_lo", dut_if.o_clk_out,     exp_clk(0.75));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 600 && m_phase != ph; i++) step(1, 0, 0);
    chk("phase_timeout", m_phase, ph);
  endtask

  task automatic wait_applied();
    for (int i = 0; i < 600 && m_pend; i++) step(1, 0, 0);
    chk("switch_timeout", dut_if.o_busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk"},  dut_if.o_clk_out,     0);
    chk({tag, "_ack"},  dut_if.o_div_ack,     0);
    chk({tag, "_busy"}, dut_if.o_busy,        0);
    chk({tag, "_err"},  dut_if.o_err,         0);
    chk({tag, "_tick"}, dut_if.o_period_tick, 0);
  endtask

  initial begin
    int sweep[4];
    int r, v;
    sweep[0] = 2; sweep[1] = 3; sweep[2] = 7; sweep[3] = 255;
    dut_if.i_en = 1'b0; dut_if.i_div_req = 1'b0; dut_if.i_div_val = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #(T/4);
    chk_all_zero("rst");
    rstn = 1'b1;

    // default ratio 5 from reset
    idle(20);

    // 5 -> 4 requested at cnt==1
    wait_phase(1);
    step(1, 1, 4);
    idle(14);

    // sweep through even/odd/min/max ratios
    for (int k = 0; k < 4; k++) begin
      step(1, 1, sweep[k]);
      wait_applied();
      idle(2 * sweep[k] + 2);
    end

    // illegal ratios, then a request while busy is dropped
    step(1, 1, 0);
    idle(3);
    step(1, 1, 1);
    idle(3);
    step(1, 1, 6);
    step(1, 1, 9);
    wait_applied();
    idle(12);

    // stop mid-period at N=6, then restart
    wait_phase(2);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    idle(13);

    // async reset in the middle of a switch to 9
    step(1, 1, 9);
    idle(3);
    chk("pre_rst_busy", dut_if.o_busy, 1);
    rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    #(T/4);
    chk_all_zero("hold_rst");
    rstn = 1'b1;
    idle(16);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      v = $urandom_range(0, 1);
      else if (r < 9)  v = $urandom_range(2, 12);
      else             v = $urandom_range(13, 40);
      step($urandom_range(0, 19) != 0, $urandom_range(0, 11) == 0, v);
    end

    chk("rise_count", rises, m_rises);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
